// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings (also used by the transmitter)
// and parity-mode constants with a parity helper.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

    // Parity bit a correct transmitter sends for this byte in the given mode.
    function automatic logic parity_bit(input logic [7:0] data, input logic mode);
        return (mode == PARITY_ODD) ? ~(^data) : (^data);
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bus: serial line and parity mode in, byte plus status out.
interface uart_rx_if;
    logic       rx_line;
    logic       parity_mode;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       frame_err;
    logic       rx_busy;

    modport master (
        output rx_line, parity_mode,
        input  rx_data, rx_valid, parity_err, frame_err, rx_busy
    );

    modport slave (
        input  rx_line, parity_mode,
        output rx_data, rx_valid, parity_err, frame_err, rx_busy
    );
endinterface

// File: rtl/uart_sync.sv
// Two-flop synchronizer for the asynchronous serial line; resets to the idle
// (high) level so no false start edge is seen coming out of reset.
module uart_sync (
    input  logic clk,
    input  logic rstn,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_sync;

    // Two-stage resynchronisation into the clk domain.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_meta <= 1'b1;
            r_sync <= 1'b1;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, one parity bit, one stop bit.
// Samples at bit centre; errored frames are still delivered with flags.
//
// state     | meaning
// ----------+----------------------------------------------------------
// ST_IDLE   | waiting for a 1->0 transition on the synchronised line
// ST_START  | half a bit in, confirm start bit still low (else glitch)
// ST_DATA   | sample 8 data bits at bit centre, shifting in from MSB
// ST_PARITY | sample parity bit
// ST_STOP   | sample stop bit, publish byte and flags, pulse rx_valid
import uart_pkg::*;

module uart_rx #(
    parameter int CLK_FREQ  = 50_000_000,
    parameter int BAUD_RATE = 9600
) (
    input logic      clk,
    input logic      rstn,
    uart_rx_if.slave bus
);
    localparam int BAUD_CNT_MAX = CLK_FREQ / BAUD_RATE;
    localparam int HALF_CNT     = BAUD_CNT_MAX / 2;
    localparam int CNT_W        = $clog2(BAUD_CNT_MAX);

    localparam logic [CNT_W-1:0] LP_CNT_FULL = CNT_W'(BAUD_CNT_MAX - 1);
    localparam logic [CNT_W-1:0] LP_CNT_HALF = CNT_W'(HALF_CNT - 1);

    logic             w_rx_s;
    logic             r_rx_prev;
    uart_state_t      r_state;
    logic [CNT_W-1:0] r_baud_cnt;
    logic [2:0]       r_bit_idx;
    logic [7:0]       r_shift;
    logic             r_par_mode;
    logic             r_par_bit;
    logic [7:0]       r_rx_data;
    logic             r_rx_valid;
    logic             r_parity_err;
    logic             r_frame_err;

    uart_sync u_sync (
        .clk  (clk),
        .rstn (rstn),
        .i_d  (bus.rx_line),
        .o_q  (w_rx_s)
    );

    // Receive FSM; the previous-sample register makes edge detection require
    // the line to be high first, which also blocks re-triggering on a break.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_rx_prev    <= 1'b1;
            r_state      <= ST_IDLE;
            r_baud_cnt   <= '0;
            r_bit_idx    <= '0;
            r_shift      <= '0;
            r_par_mode   <= PARITY_EVEN;
            r_par_bit    <= 1'b0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_parity_err <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            r_rx_prev  <= w_rx_s;
            r_rx_valid <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (r_rx_prev && !w_rx_s) begin
                        r_state    <= ST_START;
                        r_baud_cnt <= '0;
                        r_bit_idx  <= '0;
                    end
                end
                ST_START: begin
                    if (r_baud_cnt == LP_CNT_HALF) begin
                        r_baud_cnt <= '0;
                        if (!w_rx_s) begin
                            r_state    <= ST_DATA;
                            r_par_mode <= bus.parity_mode;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (r_baud_cnt == LP_CNT_FULL) begin
                        r_baud_cnt <= '0;
                        r_shift    <= {w_rx_s, r_shift[7:1]};
                        r_bit_idx  <= r_bit_idx + 1'b1;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= ST_PARITY;
                        end
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (r_baud_cnt == LP_CNT_FULL) begin
                        r_baud_cnt <= '0;
                        r_par_bit  <= w_rx_s;
                        r_state    <= ST_STOP;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (r_baud_cnt == LP_CNT_FULL) begin
                        r_baud_cnt   <= '0;
                        r_rx_data    <= r_shift;
                        r_parity_err <= (r_par_bit != parity_bit(r_shift, r_par_mode));
                        r_frame_err  <= ~w_rx_s;
                        r_rx_valid   <= 1'b1;
                        r_state      <= ST_IDLE;
                    end else begin
                        r_baud_cnt <= r_baud_cnt + 1'b1;
                    end
                end
                default: begin
                    r_state    <= ST_IDLE;
                    r_baud_cnt <= '0;
                end
            endcase
        end
    end

    assign bus.rx_data    = r_rx_data;
    assign bus.rx_valid   = r_rx_valid;
    assign bus.parity_err = r_parity_err;
    assign bus.frame_err  = r_frame_err;
    assign bus.rx_busy    = (r_state != ST_IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx. Runs with a 20-clock bit period so every
// scenario fits in a short run; sampling geometry is the same as at 9600 baud.
module tb_uart_rx;
    localparam int CLK_FREQ  = 2_000_000;
    localparam int BAUD_RATE = 100_000;
    localparam int BIT       = CLK_FREQ / BAUD_RATE;   // 20 clocks per bit
    localparam int HALF      = BIT / 2;                // 10

    logic clk;
    logic rstn;
    int   n_checks;
    int   n_errs;
    int   n_pulses;
    int   exp_pulses;
    int   busy_cnt;

    uart_rx_if bus ();

    uart_rx #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count rx_valid pulses, sampled away from the rising edge.
    always @(negedge clk) begin
        if (bus.rx_valid === 1'b1) n_pulses <= n_pulses + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errs++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        bus.rx_line = b;
        repeat (BIT) @(negedge clk);
    endtask

    // Start, 8 data LSB first, parity, stop. flip_bit >= 0 toggles
    // parity_mode just before that data bit goes out.
    task automatic send_frame(input logic [7:0] d, input logic par, input logic stp,
                              input int flip_bit);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) begin
            if (i == flip_bit) bus.parity_mode = ~bus.parity_mode;
            send_bit(d[i]);
        end
        send_bit(par);
        send_bit(stp);
    endtask

    initial begin
        n_checks    = 0;
        n_errs      = 0;
        n_pulses    = 0;
        exp_pulses  = 0;
        rstn        = 1'b0;
        bus.rx_line = 1'b1;
        bus.parity_mode = 1'b0;
        repeat (5) @(negedge clk);

        check("rst_valid", 32'(bus.rx_valid), 32'h0);
        check("rst_busy",  32'(bus.rx_busy),  32'h0);
        check("rst_data",  32'(bus.rx_data),  32'h0);
        check("rst_perr",  32'(bus.parity_err), 32'h0);
        check("rst_ferr",  32'(bus.frame_err),  32'h0);

        rstn = 1'b1;
        repeat (BIT) @(negedge clk);

        // 0xA5 even parity: four ones -> parity bit 0
        send_frame(8'hA5, 1'b0, 1'b1, -1);
        exp_pulses++;
        check("a5_pulses", 32'(n_pulses), 32'(exp_pulses));
        check("a5_data",   32'(bus.rx_data), 32'hA5);
        check("a5_perr",   32'(bus.parity_err), 32'h0);
        check("a5_ferr",   32'(bus.frame_err),  32'h0);
        check("a5_busy",   32'(bus.rx_busy),    32'h0);

        // 0x3C odd parity: correct bit is 1, send 0 instead
        bus.parity_mode = 1'b1;
        send_frame(8'h3C, 1'b0, 1'b1, -1);
        exp_pulses++;
        check("3c_pulses", 32'(n_pulses), 32'(exp_pulses));
        check("3c_data",   32'(bus.rx_data), 32'h3C);
        check("3c_perr",   32'(bus.parity_err), 32'h1);
        check("3c_ferr",   32'(bus.frame_err),  32'h0);

        // 0x3C odd parity with the correct bit clears the parity flag
        send_frame(8'h3C, 1'b1, 1'b1, -1);
        exp_pulses++;
        check("3c_ok_pulses", 32'(n_pulses), 32'(exp_pulses));
        check("3c_ok_perr",   32'(bus.parity_err), 32'h0);

        // 0x01 even parity: correct bit 1, send 0
        bus.parity_mode = 1'b0;
        send_frame(8'h01, 1'b0, 1'b1, -1);
        exp_pulses++;
        check("01_data", 32'(bus.rx_data), 32'h01);
        check("01_perr", 32'(bus.parity_err), 32'h1);

        // 0x81 even parity bit 0, stop forced low, line held low 2 more bits
        send_frame(8'h81, 1'b0, 1'b0, -1);
        exp_pulses++;
        check("81_pulses", 32'(n_pulses), 32'(exp_pulses));
        check("81_data",   32'(bus.rx_data), 32'h81);
        check("81_ferr",   32'(bus.frame_err),  32'h1);
        check("81_perr",   32'(bus.parity_err), 32'h0);
        repeat (2 * BIT) @(negedge clk);
        check("brk_pulses", 32'(n_pulses), 32'(exp_pulses));
        check("brk_busy",   32'(bus.rx_busy), 32'h0);
        bus.rx_line = 1'b1;
        repeat (2 * BIT) @(negedge clk);
        check("brk_hi_pulses", 32'(n_pulses), 32'(exp_pulses));
        check("brk_ferr_hold", 32'(bus.frame_err), 32'h1);

        // 3-clock low glitch on idle line: busy for exactly HALF clocks
        busy_cnt = 0;
        bus.rx_line = 1'b0;
        for (int i = 0; i < 3 * BIT; i++) begin
            @(negedge clk);
            if (i == 2) bus.rx_line = 1'b1;
            if (bus.rx_busy === 1'b1) busy_cnt++;
        end
        check("glitch_busy_cnt", 32'(busy_cnt), 32'(HALF));
        check("glitch_pulses",   32'(n_pulses), 32'(exp_pulses));
        check("glitch_busy_end", 32'(bus.rx_busy), 32'h0);
        check("glitch_ferr",     32'(bus.frame_err), 32'h1);

        // Back-to-back 0x00 then 0xFF (both even parity bit 0)
        send_frame(8'h00, 1'b0, 1'b1, -1);
        exp_pulses++;
        check("b2b0_pulses", 32'(n_pulses), 32'(exp_pulses));
        check("b2b0_data",   32'(bus.rx_data), 32'h00);
        check("b2b0_ferr",   32'(bus.frame_err), 32'h0);
        send_frame(8'hFF, 1'b0, 1'b1, -1);
        exp_pulses++;
        check("b2b1_pulses", 32'(n_pulses), 32'(exp_pulses));
        check("b2b1_data",   32'(bus.rx_data), 32'hFF);
        check("b2b1_perr",   32'(bus.parity_err), 32'h0);
        check("b2b1_ferr",   32'(bus.frame_err),  32'h0);

        // parity_mode flipped mid-frame: frame keeps even mode, 0xA5 bit 0
        send_frame(8'hA5, 1'b0, 1'b1, 3);
        exp_pulses++;
        bus.parity_mode = 1'b0;
        check("flip_pulses", 32'(n_pulses), 32'(exp_pulses));
        check("flip_perr",   32'(bus.parity_err), 32'h0);

        // Reset during bit 4 of 0xC3
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b0);
        send_bit(1'b0);
        bus.rx_line = 1'b0;
        repeat (HALF) @(negedge clk);
        rstn = 1'b0;
        bus.rx_line = 1'b1;
        @(negedge clk);
        check("mid_rst_busy", 32'(bus.rx_busy), 32'h0);
        check("mid_rst_data", 32'(bus.rx_data), 32'h0);
        repeat (4) @(negedge clk);
        rstn = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        check("mid_rst_pulses", 32'(n_pulses), 32'(exp_pulses));

        // Clean 0x5A (four ones -> even parity bit 0)
        send_frame(8'h5A, 1'b0, 1'b1, -1);
        exp_pulses++;
        check("5a_pulses", 32'(n_pulses), 32'(exp_pulses));
        check("5a_data",   32'(bus.rx_data), 32'h5A);
        check("5a_perr",   32'(bus.parity_err), 32'h0);
        check("5a_ferr",   32'(bus.frame_err),  32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
        $finish;
    end
endmodule
